// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline buffer: two-entry FIFO of {pc, instruction} beats
// with branch flush and a NOP bubble toward decode whenever it is empty.
module if_id_buffer #(
  parameter int unsigned         WIDTH = 32,
  parameter logic [WIDTH-1:0]    NOP   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [WIDTH-1:0] if_instruction,
  output logic             if_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_instruction,
  input  logic             id_ready
);

  logic [WIDTH-1:0] pc_mem  [2];
  logic [WIDTH-1:0] ins_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] hold_pc;
  logic             push;
  logic             pop;

  assign if_ready = (count != 2'd2) && !reset;
  assign id_valid = (count != 2'd0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  // Empty buffer keeps showing the most recently presented pc instead of stale entries.
  assign id_pc          = id_valid ? pc_mem[rd_ptr]  : hold_pc;
  assign id_instruction = id_valid ? ins_mem[rd_ptr] : NOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      hold_pc <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      if (count != 2'd0) hold_pc <= pc_mem[rd_ptr];
    end else begin
      if (push) begin
        pc_mem[wr_ptr]  <= if_pc;
        ins_mem[wr_ptr] <= if_instruction;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        hold_pc <= pc_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: accepted beats are queued, and every
// beat decode consumes is checked against the queue head in FIFO order.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb [$];
  logic [31:0] last_pc;
  logic        last_pc_known;

  if_id_buffer #(.WIDTH(32), .NOP(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_instruction(id_instruction), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0013;
  endfunction

  // Called just after a falling edge: drive inputs, check outputs against the
  // model, update the model for the coming rising edge, advance one cycle.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    logic [63:0] head;
    int unsigned n;
    if_valid       = v;
    if_pc          = pc;
    if_instruction = mk_ins(pc);
    id_ready       = rdy;
    flush          = fl;
    #1;
    n = sb.size();
    chk("if_ready", {31'b0, if_ready}, {31'b0, n != 2});
    chk("id_valid", {31'b0, id_valid}, {31'b0, n != 0});
    if (n == 0) begin
      chk("nop", id_instruction, 32'h0000_0000);
      if (last_pc_known) chk("hold_pc", id_pc, last_pc);
    end
    if (fl) begin
      if (n != 0) last_pc_known = 1'b0;
      sb.delete();
    end else begin
      if (n != 0 && rdy) begin
        head = sb.pop_front();
        chk("pop_pc", id_pc, head[63:32]);
        chk("pop_ins", id_instruction, head[31:0]);
        last_pc       = head[63:32];
        last_pc_known = 1'b1;
      end
      if (v && n != 2) sb.push_back({pc, mk_ins(pc)});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0;
    if_instruction = '0; id_ready = 1'b0;
    last_pc = '0; last_pc_known = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_ins", id_instruction, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // streaming
    step(1'b1, 32'h00, 1'b1, 1'b0);
    step(1'b1, 32'h04, 1'b1, 1'b0);
    step(1'b1, 32'h08, 1'b1, 1'b0);
    drain();

    // stall absorbs two beats, third held off until space returns
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b0, 1'b0);
    step(1'b1, 32'h18, 1'b0, 1'b0);
    step(1'b1, 32'h18, 1'b1, 1'b0);
    step(1'b1, 32'h18, 1'b1, 1'b0);
    drain();

    // flush drops held and incoming beats
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h24, 1'b0, 1'b0);
    step(1'b1, 32'h28, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b0);
    drain();

    // simultaneous push and pop at count 1
    step(1'b1, 32'h2c, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b1, 1'b0);
    drain();

    // mixed traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(i * 4),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    drain();

    // asynchronous reset while full
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    if_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_if_ready", {31'b0, if_ready}, 32'd0);
    chk("arst_id_ins", id_instruction, 32'h0);
    chk("arst_id_pc", id_pc, 32'h0);
    sb.delete();
    last_pc = '0;
    last_pc_known = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h50, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
